// File: rtl/flag_ckpt_reg.sv
// Condition flag register with per-flag write enables, optional sticky bits,
// and a FIFO of flag snapshots for speculative-branch recovery.
module flag_ckpt_reg #(
  parameter int unsigned          NUM_FLAGS   = 3,
  parameter int unsigned          CKPT_DEPTH  = 4,
  parameter logic [NUM_FLAGS-1:0] STICKY_MASK = {NUM_FLAGS{1'b0}}
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_FLAGS-1:0]          flag_en,
  input  logic [NUM_FLAGS-1:0]          flag_set,
  input  logic                          sticky_clr,
  input  logic                          ckpt_push,
  input  logic                          ckpt_commit,
  input  logic                          ckpt_restore,
  output logic [NUM_FLAGS-1:0]          flags,
  output logic [$clog2(CKPT_DEPTH):0]   ckpt_count,
  output logic                          ckpt_full,
  output logic                          ckpt_empty,
  output logic                          ckpt_err
);

  localparam int unsigned PTR_W = $clog2(CKPT_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [NUM_FLAGS-1:0] flags_q, flags_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 err_q, err_d;
  logic [NUM_FLAGS-1:0] mem_q [CKPT_DEPTH];
  logic [NUM_FLAGS-1:0] mem_d [CKPT_DEPTH];

  logic                 empty_c;
  logic                 full_c;
  logic                 restore_ok_c;
  logic                 do_push_c;
  logic                 do_commit_c;
  logic [NUM_FLAGS-1:0] wr_ones_c;

  assign empty_c = (count_q == CNT_W'(0));
  assign full_c  = (count_q == CNT_W'(CKPT_DEPTH));

  // Next-state: a valid restore overrides every other same-cycle request.
  always_comb begin
    flags_d      = flags_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    err_d        = 1'b0;
    mem_d        = mem_q;
    do_push_c    = 1'b0;
    do_commit_c  = 1'b0;
    wr_ones_c    = flag_en & flag_set;
    restore_ok_c = ckpt_restore && !empty_c;

    if (restore_ok_c) begin
      flags_d  = mem_q[rd_ptr_q];
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      flags_d = (STICKY_MASK & ((sticky_clr ? '0 : flags_q) | wr_ones_c))
              | (~STICKY_MASK & (wr_ones_c | (~flag_en & flags_q)));

      // A commit frees a slot, so a push against a full FIFO is legal with it.
      do_commit_c = ckpt_commit && !empty_c;
      do_push_c   = ckpt_push && (!full_c || do_commit_c);

      if (do_push_c) begin
        mem_d[wr_ptr_q] = flags_q;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_commit_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push_c) - CNT_W'(do_commit_c);
      err_d   = (ckpt_push && !do_push_c) || (ckpt_commit && !do_commit_c)
              || ckpt_restore;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      flags_q  <= flags_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Snapshot storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign flags      = flags_q;
  assign ckpt_count = count_q;
  assign ckpt_err   = err_q;
  assign ckpt_full  = full_c;
  assign ckpt_empty = empty_c;

endmodule
